// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types: access kinds, transaction-arbiter FSM states and the
// bundled request record latched by rv_iopmp_tl_arbiter.
// The request record is sized for the widest supported configuration
// (64-bit address/length, up to 8-bit beat size, up to 16-bit source ID).
// Narrower configurations zero-extend into it.
package rv_iopmp_pkg;

  typedef enum logic [1:0] {
    ACCESS_NONE      = 2'b00,
    ACCESS_READ      = 2'b01,
    ACCESS_WRITE     = 2'b10,
    ACCESS_EXECUTION = 2'b11
  } access_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_ISSUE = 2'b01,
    ARB_WAIT  = 2'b10
  } arb_state_e;

  localparam int unsigned TL_MAX_ADDR_W = 64;
  localparam int unsigned TL_MAX_NB_W   = 8;
  localparam int unsigned TL_MAX_SID_W  = 16;

  typedef struct packed {
    logic [TL_MAX_ADDR_W-1:0] addr;
    logic [TL_MAX_ADDR_W-1:0] total_length;
    logic [TL_MAX_NB_W-1:0]   num_bytes;
    logic [TL_MAX_SID_W-1:0]  sid;
    access_t                  access_type;
  } tl_req_t;

endpackage

// File: rtl/rv_iopmp_rr_arbiter.sv
// Combinational round-robin grant: the first requester at or after the
// pointer wins, wrapping around to index 0.
module rv_iopmp_rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] rr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [N-1:0] hi;
  logic [N-1:0] pick;

  // Prefer requests at/above the pointer; fall back to the lowest request overall.
  always_comb begin
    hi = '0;
    for (int i = 0; i < N; i++) begin
      hi[i] = req_i[i] && (IDX_W'(i) >= rr_i);
    end
    pick  = (|hi) ? hi : req_i;
    gnt_o = '0;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pick[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
      end
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/rv_iopmp_tl_arbiter.sv
// Round-robin arbiter sharing one IOPMP matching-logic instance among
// several data abstractors. One check is in flight at a time; the verdict
// is steered back only to the requester that owns it.
// Optional watchdog: define RV_IOPMP_ARB_TIMEOUT_EN to deny a check whose
// verdict has not arrived within TIMEOUT_CYCLES of entering WAIT.
module rv_iopmp_tl_arbiter
  import rv_iopmp_pkg::*;
#(
  parameter int unsigned NUMBER_TL_INSTANCES = 2,
  parameter int unsigned ADDR_WIDTH          = 64,
  parameter int unsigned DATA_WIDTH          = 64,
  parameter int unsigned SID_WIDTH           = 1,
  parameter int unsigned TIMEOUT_CYCLES      = 64,
  localparam int unsigned NB_W  = $clog2(DATA_WIDTH / 8) + 1,
  localparam int unsigned IDX_W = (NUMBER_TL_INSTANCES > 1) ? $clog2(NUMBER_TL_INSTANCES) : 1
) (
  input  logic                                           clk_i,
  input  logic                                           rst_ni,
  input  logic [NUMBER_TL_INSTANCES-1:0]                 req_transaction_en_i,
  input  logic [NUMBER_TL_INSTANCES-1:0][ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUMBER_TL_INSTANCES-1:0][ADDR_WIDTH-1:0] req_total_length_i,
  input  logic [NUMBER_TL_INSTANCES-1:0][NB_W-1:0]       req_num_bytes_i,
  input  logic [NUMBER_TL_INSTANCES-1:0][SID_WIDTH-1:0]  req_sid_i,
  input  access_t [NUMBER_TL_INSTANCES-1:0]              req_access_type_i,
  output logic [NUMBER_TL_INSTANCES-1:0]                 req_ready_o,
  output logic [NUMBER_TL_INSTANCES-1:0]                 req_valid_o,
  output logic [NUMBER_TL_INSTANCES-1:0]                 req_allow_transaction_o,
  output logic                                           ml_transaction_en_o,
  output logic [ADDR_WIDTH-1:0]                          ml_addr_o,
  output logic [ADDR_WIDTH-1:0]                          ml_total_length_o,
  output logic [NB_W-1:0]                                ml_num_bytes_o,
  output logic [SID_WIDTH-1:0]                           ml_sid_o,
  output access_t                                        ml_access_type_o,
  input  logic                                           ml_ready_i,
  input  logic                                           ml_valid_i,
  input  logic                                           ml_allow_transaction_i,
  input  logic                                           stall_i,
  output logic [IDX_W-1:0]                               grant_idx_o,
  output logic                                           busy_o,
  output logic                                           timeout_o
);

  localparam int unsigned N = NUMBER_TL_INSTANCES;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] gnt_q;
  tl_req_t          req_q;
  tl_req_t          req_sel_c;

  logic [N-1:0]     gnt_oh_c;
  logic [IDX_W-1:0] gnt_idx_c;
  logic             any_c;
  logic             grant_c;
  logic             issue_done_c;
  logic             verdict_c;
  logic             expire_c;
  logic [N-1:0]     owner_oh_c;
  logic             unused_pad;

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] g);
    if (g == IDX_W'(N - 1)) return '0;
    return g + 1'b1;
  endfunction

  rv_iopmp_rr_arbiter #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req_i (req_transaction_en_i),
    .rr_i  (rr_q),
    .gnt_o (gnt_oh_c),
    .idx_o (gnt_idx_c),
    .any_o (any_c)
  );

  assign grant_c      = (state_q == ARB_IDLE) && any_c && !stall_i;
  assign issue_done_c = (state_q == ARB_ISSUE) && ml_ready_i;
  assign verdict_c    = (state_q == ARB_WAIT) && (ml_valid_i || expire_c);

`ifdef RV_IOPMP_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] wait_cnt_q;

  // A real verdict in the expiry cycle wins over the watchdog.
  assign expire_c = (state_q == ARB_WAIT) && !ml_valid_i &&
                    (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter: cleared on entry to WAIT, counts every WAIT cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
    end else if (issue_done_c) begin
      wait_cnt_q <= '0;
    end else if (state_q == ARB_WAIT) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end
`else
  assign expire_c = 1'b0;
`endif

  // Field mux of the granted requester, widened into the shared record.
  always_comb begin
    req_sel_c = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_oh_c[i]) begin
        req_sel_c.addr         = TL_MAX_ADDR_W'(req_addr_i[i]);
        req_sel_c.total_length = TL_MAX_ADDR_W'(req_total_length_i[i]);
        req_sel_c.num_bytes    = TL_MAX_NB_W'(req_num_bytes_i[i]);
        req_sel_c.sid          = TL_MAX_SID_W'(req_sid_i[i]);
        req_sel_c.access_type  = req_access_type_i[i];
      end
    end
  end

  // State register and round-robin pointer; the pointer moves past the owner on each verdict.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      if (verdict_c) rr_q <= rr_next(gnt_q);
    end
  end

  // Latched request and owner index, captured at grant and held through WAIT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q <= '0;
      gnt_q <= '0;
    end else if (grant_c) begin
      req_q <= req_sel_c;
      gnt_q <= gnt_idx_c;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:  if (grant_c)    state_d = ARB_ISSUE;
      ARB_ISSUE: if (ml_ready_i) state_d = ARB_WAIT;
      ARB_WAIT:  if (verdict_c)  state_d = ARB_IDLE;
      default:                   state_d = ARB_IDLE;
    endcase
  end

  // Handshake outputs; verdicts are passed through combinationally to the owner only.
  always_comb begin
    req_ready_o             = '0;
    req_valid_o             = '0;
    req_allow_transaction_o = '0;
    ml_transaction_en_o     = 1'b0;
    timeout_o               = 1'b0;
    owner_oh_c              = '0;
    for (int i = 0; i < N; i++) begin
      owner_oh_c[i] = (gnt_q == IDX_W'(i));
    end
    // Requests held across reset must not see an acceptance pulse.
    if (grant_c && rst_ni) req_ready_o = gnt_oh_c;
    if (state_q == ARB_ISSUE) ml_transaction_en_o = 1'b1;
    if (verdict_c) begin
      req_valid_o             = owner_oh_c;
      req_allow_transaction_o = owner_oh_c & {N{ml_valid_i & ml_allow_transaction_i}};
      timeout_o               = expire_c;
    end
  end

  assign ml_addr_o         = req_q.addr[ADDR_WIDTH-1:0];
  assign ml_total_length_o = req_q.total_length[ADDR_WIDTH-1:0];
  assign ml_num_bytes_o    = req_q.num_bytes[NB_W-1:0];
  assign ml_sid_o          = req_q.sid[SID_WIDTH-1:0];
  assign ml_access_type_o  = req_q.access_type;
  assign grant_idx_o       = gnt_q;
  assign busy_o            = (state_q != ARB_IDLE);

  // Record bits above the configured widths never leave the block.
  assign unused_pad = ^req_q;

endmodule

// File: tb/tb_rv_iopmp_tl_arbiter.sv
// Self-checking bench for rv_iopmp_tl_arbiter (two requesters). Expected
// verdicts are queued when a request is launched and retired by a monitor
// whenever the arbiter raises req_valid_o. Build with RV_IOPMP_ARB_TIMEOUT_EN
// defined to exercise the watchdog (TIMEOUT_CYCLES = 8).
module tb_rv_iopmp_tl_arbiter;
  import rv_iopmp_pkg::*;

  localparam int N   = 2;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int SW  = 1;
  localparam int TO  = 8;
  localparam int NBW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]          req_en;
  logic [N-1:0][AW-1:0]  req_addr;
  logic [N-1:0][AW-1:0]  req_len;
  logic [N-1:0][NBW-1:0] req_nb;
  logic [N-1:0][SW-1:0]  req_sid;
  access_t [N-1:0]       req_at;
  logic [N-1:0]          req_ready_o, req_valid_o, req_allow_transaction_o;
  logic                  ml_transaction_en_o;
  logic [AW-1:0]         ml_addr_o, ml_total_length_o;
  logic [NBW-1:0]        ml_num_bytes_o;
  logic [SW-1:0]         ml_sid_o;
  access_t               ml_access_type_o;
  logic                  ml_ready, ml_valid, ml_allow, stall;
  logic [0:0]            grant_idx_o;
  logic                  busy_o, timeout_o;

  rv_iopmp_tl_arbiter #(
    .NUMBER_TL_INSTANCES (N),
    .ADDR_WIDTH          (AW),
    .DATA_WIDTH          (DW),
    .SID_WIDTH           (SW),
    .TIMEOUT_CYCLES      (TO)
  ) dut (
    .clk_i                   (clk),
    .rst_ni                  (rst_n),
    .req_transaction_en_i    (req_en),
    .req_addr_i              (req_addr),
    .req_total_length_i      (req_len),
    .req_num_bytes_i         (req_nb),
    .req_sid_i               (req_sid),
    .req_access_type_i       (req_at),
    .req_ready_o             (req_ready_o),
    .req_valid_o             (req_valid_o),
    .req_allow_transaction_o (req_allow_transaction_o),
    .ml_transaction_en_o     (ml_transaction_en_o),
    .ml_addr_o               (ml_addr_o),
    .ml_total_length_o       (ml_total_length_o),
    .ml_num_bytes_o          (ml_num_bytes_o),
    .ml_sid_o                (ml_sid_o),
    .ml_access_type_o        (ml_access_type_o),
    .ml_ready_i              (ml_ready),
    .ml_valid_i              (ml_valid),
    .ml_allow_transaction_i  (ml_allow),
    .stall_i                 (stall),
    .grant_idx_o             (grant_idx_o),
    .busy_o                  (busy_o),
    .timeout_o               (timeout_o)
  );

  typedef struct {
    int unsigned who;
    bit          allow;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Verdict monitor: every req_valid_o pulse retires the oldest expectation.
  always begin
    @(negedge clk);
    #2;
    if (req_valid_o !== '0) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 64'(req_valid_o), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("vld_owner", 64'(req_valid_o), 64'd1 << mon_e.who);
        chk("vld_allow", 64'(req_allow_transaction_o), mon_e.allow ? (64'd1 << mon_e.who) : 64'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running, want done");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n    = 1'b0;
    req_en   = '0;
    ml_ready = 1'b0;
    ml_valid = 1'b0;
    ml_allow = 1'b0;
    stall    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete check for requester 'who', starting at a negedge with the DUT in IDLE.
  task automatic run_check(input int unsigned who, input bit allow, input int rdy_wait,
                           input int vld_wait, input bit drop);
    logic [AW-1:0] ea, el;
    logic [1:0]    eat;
    ea  = req_addr[who[0]];
    el  = req_len[who[0]];
    eat = req_at[who[0]];
    #1;
    chk("ready", 64'(req_ready_o), 64'd1 << who);
    exp_q.push_back('{who: who, allow: allow});
    for (int k = 0; k <= rdy_wait; k++) begin
      @(negedge clk);
      if (drop && k == 0) begin
        req_en[who[0]]   = 1'b0;
        req_addr[who[0]] = ~ea;
        req_len[who[0]]  = ~el;
      end
      ml_ready = (k == rdy_wait);
      #1;
      chk("issue_en", 64'(ml_transaction_en_o), 64'd1);
      chk("issue_addr", ml_addr_o, ea);
      chk("issue_len", ml_total_length_o, el);
      chk("issue_at", 64'(ml_access_type_o), 64'(eat));
      chk("issue_gidx", 64'(grant_idx_o), 64'(who));
      chk("issue_no_ready", 64'(req_ready_o), 64'd0);
    end
    for (int k = 0; k <= vld_wait; k++) begin
      @(negedge clk);
      ml_ready = 1'b0;
      ml_valid = (k == vld_wait);
      ml_allow = allow;
      #1;
      chk("wait_en", 64'(ml_transaction_en_o), 64'd0);
      chk("wait_busy", 64'(busy_o), 64'd1);
      chk("wait_addr", ml_addr_o, ea);
      chk("wait_timeout", 64'(timeout_o), 64'd0);
      if (k < vld_wait) begin
        chk("early_valid", 64'(req_valid_o), 64'd0);
        chk("early_allow", 64'(req_allow_transaction_o), 64'd0);
      end
    end
    @(negedge clk);
    ml_valid = 1'b0;
    ml_allow = 1'b0;
    if (drop) begin
      req_addr[who[0]] = ea;
      req_len[who[0]]  = el;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    req_en   = 2'b11;
    req_addr = '0;
    req_len  = '0;
    req_nb   = '0;
    req_sid  = '0;
    req_at   = {ACCESS_WRITE, ACCESS_READ};
    ml_ready = 1'b0;
    ml_valid = 1'b0;
    ml_allow = 1'b0;
    stall    = 1'b0;

    // Reset state: everything quiet even with requests pending.
    @(negedge clk);
    #1;
    chk("rst_ready", 64'(req_ready_o), 64'd0);
    chk("rst_ctrl", 64'({req_valid_o, req_allow_transaction_o, ml_transaction_en_o,
                         busy_o, timeout_o, grant_idx_o}), 64'd0);
    chk("rst_addr", ml_addr_o, 64'd0);

    // Single request with 2-cycle answer, requester drops after acceptance.
    do_reset();
    req_addr[0] = 64'h8000_0000;
    req_len[0]  = 64'h40;
    req_nb[0]   = 4'd8;
    req_en[0]   = 1'b1;
    run_check(0, 1'b1, 0, 1, 1'b1);

    // Contention: both held, 1-cycle answers, deny on the second check.
    do_reset();
    req_addr[0] = 64'h1000;
    req_addr[1] = 64'h2000;
    req_len[1]  = 64'h80;
    req_en      = 2'b11;
    run_check(0, 1'b1, 0, 0, 1'b0);
    run_check(1, 1'b0, 0, 0, 1'b0);
    run_check(0, 1'b1, 0, 0, 1'b0);
    run_check(1, 1'b1, 0, 0, 1'b0);
    req_en = 2'b00;
    @(negedge clk);
    #1;
    chk("idle_after_contention", 64'(busy_o), 64'd0);

    // Stall holds off the grant; grant lands in the cycle stall falls.
    do_reset();
    stall     = 1'b1;
    req_en[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_ready", 64'(req_ready_o), 64'd0);
      chk("stall_busy", 64'(busy_o), 64'd0);
      @(negedge clk);
    end
    stall = 1'b0;
    run_check(1, 1'b0, 0, 2, 1'b1);

    // Issue backpressure: three cycles of ml_ready low.
    do_reset();
    req_addr[0] = 64'hDEAD_BEEF_0000_1000;
    req_len[0]  = 64'h100;
    req_en[0]   = 1'b1;
    run_check(0, 1'b1, 3, 0, 1'b1);

    // Reset mid-WAIT: the pending verdict is dropped and the pointer restarts at 0.
    do_reset();
    req_en[0] = 1'b1;
    run_check(0, 1'b1, 0, 0, 1'b1);
    req_en[1] = 1'b1;
    #1;
    chk("rw_ready1", 64'(req_ready_o), 64'd2);
    @(negedge clk);
    req_en[1] = 1'b0;
    ml_ready  = 1'b1;
    @(negedge clk);
    ml_ready = 1'b0;
    #1;
    chk("rw_in_wait", 64'(busy_o), 64'd1);
    @(negedge clk);
    rst_n    = 1'b0;
    ml_valid = 1'b1;
    ml_allow = 1'b1;
    #1;
    chk("rw_ctrl", 64'({req_ready_o, req_valid_o, req_allow_transaction_o,
                        ml_transaction_en_o, busy_o, timeout_o, grant_idx_o}), 64'd0);
    chk("rw_addr", ml_addr_o, 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    req_en = 2'b11;
    #1;
    chk("rw_late_valid", 64'(req_valid_o), 64'd0);
    run_check(0, 1'b1, 0, 0, 1'b0);
    req_en = 2'b00;

`ifdef RV_IOPMP_ARB_TIMEOUT_EN
    // Watchdog expiry: deny plus timeout pulse 7 cycles after WAIT entry.
    do_reset();
    req_en[0] = 1'b1;
    #1;
    chk("to_ready", 64'(req_ready_o), 64'd1);
    exp_q.push_back('{who: 0, allow: 1'b0});
    @(negedge clk);
    req_en[0] = 1'b0;
    ml_ready  = 1'b1;
    #1;
    chk("to_issue", 64'(ml_transaction_en_o), 64'd1);
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      ml_ready = 1'b0;
      #1;
      chk("to_pulse", 64'(timeout_o), (k == 7) ? 64'd1 : 64'd0);
      chk("to_busy", 64'(busy_o), 64'd1);
    end
    @(negedge clk);
    ml_valid = 1'b1;
    ml_allow = 1'b1;
    #1;
    chk("to_late_valid", 64'(req_valid_o), 64'd0);
    chk("to_idle", 64'(busy_o), 64'd0);
    @(negedge clk);
    ml_valid = 1'b0;
    ml_allow = 1'b0;
    // Verdict in the expiry cycle wins; pointer had advanced to requester 1.
    req_en = 2'b11;
    run_check(1, 1'b1, 0, 7, 1'b1);
    req_en = 2'b00;
`else
    // Without the watchdog WAIT is unbounded and timeout_o never fires.
    do_reset();
    req_en[0] = 1'b1;
    run_check(0, 1'b1, 0, 40, 1'b1);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
